// File: rtl/count_trk_pkg.sv
// count_trk_pkg
//   Shared types and constants for the counter wrap tracker.
//   - trk_state_t : tracker FSM states (IDLE = no previous sample, TRACK = comparing samples)
//   - wrap_evt_t  : layout of one queued wrap event {dir, wrap count after the wrap}
//   - DIR_UP / DIR_DOWN : encoding of the counter's mode input
//   - *_DEF       : default parameter values used by the tracker top
package count_trk_pkg;

    localparam int CW_DEF     = 4;
    localparam int WRAP_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } trk_state_t;

    typedef struct packed {
        logic                         dir;
        logic signed [WRAP_W_DEF-1:0] wcnt;
    } wrap_evt_t;

endpackage

// File: rtl/wrap_evt_fifo.sv
// wrap_evt_fifo
//   Synchronous DEPTH-entry FIFO carrying wrap events on a valid/ready stream.
//   Pointers carry one extra bit so full and empty are told apart without a counter.
//   A push into a full FIFO is accepted when a pop happens in the same cycle;
//   otherwise it is discarded and reported on 'drop' for that cycle.
//   The head entry is held in a register (dout) together with 'valid'.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data
//   ready      : consumer accepts the head entry this cycle
//   valid      : head entry available (registered)
//   dout       : head entry, zero when empty (registered)
//   drop       : push lost because the FIFO was full with no pop (combinational pulse)
module wrap_evt_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW:0]   wr_nxt, rd_nxt;
    logic          full, pop, push_ok, head_from_din;
    logic [W-1:0]  dout_nxt;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = valid & ready;
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    assign wr_nxt  = wr_ptr + {{AW{1'b0}}, push_ok};
    assign rd_nxt  = rd_ptr + {{AW{1'b0}}, pop};

    // The pushed word becomes the new head when nothing else remains after the pop.
    assign head_from_din = push_ok && (rd_nxt == wr_ptr);

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        dout_nxt = '0;
        if (wr_nxt != rd_nxt) begin
            if (head_from_din) dout_nxt = din;
            else               dout_nxt = mem[rd_nxt[AW-1:0]];
        end
    end

    // NOTE: storage has no reset; validity is tracked by the pointers, and leaving the
    // array unreset lets it map onto plain registers or RAM without a reset network.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            valid  <= 1'b0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            valid  <= (wr_nxt != rd_nxt);
            dout   <= dout_nxt;
        end
    end

endmodule

// File: rtl/count_wrap_tracker.sv
// count_wrap_tracker
//   Watches a CW-bit up/down counter sample by sample, detects wrap-around
//   (MAX->0 in up mode, 0->MAX in down mode) and keeps a signed wrap count.
//   pos = {wrap_cnt, last count} is an exact two's-complement extended position.
//   Each wrap is queued as {dir, new wrap_cnt}; the event is registered once before
//   entering the FIFO, so it becomes visible one cycle after pos updates.
// Build option
//   WRAP_TRACK_STEP_CHK_EN : when defined, flags any sample that is not exactly one
//   step from the previous one in the current mode (a hold counts as illegal).
//   When undefined, step_err is tied low.
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   cnt_vld             : count_in / dir_in / cnt_rst valid this cycle
//   count_in, dir_in    : counter value and mode (1 = up)
//   cnt_rst             : counter's own reset applied for this sample
//   pos                 : extended position {wrap_cnt, last}
//   evt_valid/ready/data: wrap event stream {dir_of_wrap, wrap_cnt after wrap}
//   drop_err            : sticky, event lost to a full queue
//   step_err            : sticky, illegal step seen (checker builds only)
module count_wrap_tracker
    import count_trk_pkg::*;
#(
    parameter int CW     = CW_DEF,
    parameter int WRAP_W = WRAP_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cnt_vld,
    input  logic [CW-1:0]        count_in,
    input  logic                 dir_in,
    input  logic                 cnt_rst,
    output logic [WRAP_W+CW-1:0] pos,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [WRAP_W:0]      evt_data,
    output logic                 drop_err,
    output logic                 step_err
);

    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_ZERO = '0;

    trk_state_t               state;
    logic [CW-1:0]            last;
    logic signed [WRAP_W-1:0] wrap_cnt;
    logic signed [WRAP_W-1:0] wcnt_up, wcnt_dn;
    logic                     wrap_up, wrap_dn;
    logic                     push_vld;
    logic [WRAP_W:0]          push_data;
    logic                     fifo_drop;

    assign wrap_up = (dir_in == DIR_UP)   && (last == CNT_MAX)  && (count_in == CNT_ZERO);
    assign wrap_dn = (dir_in == DIR_DOWN) && (last == CNT_ZERO) && (count_in == CNT_MAX);
    assign wcnt_up = wrap_cnt + WRAP_W'(1);
    assign wcnt_dn = wrap_cnt - WRAP_W'(1);

    assign pos = {wrap_cnt, last};

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= '0;
            wrap_cnt  <= '0;
            push_vld  <= 1'b0;
            push_data <= '0;
            drop_err  <= 1'b0;
        end else begin
            push_vld <= 1'b0;
            drop_err <= drop_err | fifo_drop;
            if (cnt_vld) begin
                case (state)
                    IDLE: begin
                        last  <= count_in;
                        state <= TRACK;
                    end
                    TRACK: begin
                        last <= count_in;
                        if (cnt_rst) begin
                            wrap_cnt <= '0;
                        end else if (wrap_up) begin
                            wrap_cnt  <= wcnt_up;
                            push_vld  <= 1'b1;
                            push_data <= {DIR_UP, wcnt_up};
                        end else if (wrap_dn) begin
                            wrap_cnt  <= wcnt_dn;
                            push_vld  <= 1'b1;
                            push_data <= {DIR_DOWN, wcnt_dn};
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef WRAP_TRACK_STEP_CHK_EN
    logic [CW-1:0] step_exp;
    logic          step_err_q;

    assign step_exp = (dir_in == DIR_UP) ? last + CW'(1) : last - CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_err_q <= 1'b0;
        end else if (cnt_vld && !cnt_rst && (state == TRACK) && (count_in != step_exp)) begin
            step_err_q <= 1'b1;
        end
    end

    assign step_err = step_err_q;
`else
    assign step_err = 1'b0;
`endif

    wrap_evt_fifo #(
        .W     (WRAP_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_vld),
        .din   (push_data),
        .ready (evt_ready),
        .valid (evt_valid),
        .dout  (evt_data),
        .drop  (fifo_drop)
    );

endmodule

// File: tb/tb_count_wrap_tracker.sv
// tb_count_wrap_tracker
//   Directed scenarios followed by a randomized walk, all compared against a
//   queue-based reference model of the tracker (default parameters CW=4, WRAP_W=8, DEPTH=4).
module tb_count_wrap_tracker;
    import count_trk_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cnt_vld = 1'b0;
    logic [3:0]  count_in = '0;
    logic        dir_in = 1'b0;
    logic        cnt_rst = 1'b0;
    logic [11:0] pos;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [8:0]  evt_data;
    logic        drop_err;
    logic        step_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_w;
    int         m_last;
    bit         m_track;
    bit         m_pend_v;
    logic [8:0] m_pend;
    logic [8:0] m_q[$];
    bit         m_drop;
    bit         m_step;

    count_wrap_tracker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_vld   (cnt_vld),
        .count_in  (count_in),
        .dir_in    (dir_in),
        .cnt_rst   (cnt_rst),
        .pos       (pos),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .drop_err  (drop_err),
        .step_err  (step_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_w = 0; m_last = 0; m_track = 0; m_pend_v = 0; m_pend = '0;
        m_q.delete(); m_drop = 0; m_step = 0;
    endtask

    task automatic check_model(input string tag);
        wrap_evt_t head;
        logic [11:0] e_pos;
        e_pos = {8'(m_w), 4'(m_last)};
        head  = (m_q.size() > 0) ? m_q[0] : '0;
        chk({tag, "_pos"},   pos,       e_pos);
        chk({tag, "_valid"}, evt_valid, m_q.size() > 0);
        chk({tag, "_data"},  evt_data,  head);
        chk({tag, "_drop"},  drop_err,  m_drop);
        chk({tag, "_step"},  step_err,  m_step);
    endtask

    // Effect of one rising edge on the model, given the inputs held across it.
    task automatic model_edge(input bit vld, input int cnt, input bit dir, input bit crst, input bit rdy);
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        if (m_pend_v) begin
            if (m_q.size() == DEPTH) m_drop = 1;
            else                     m_q.push_back(m_pend);
            m_pend_v = 0;
        end
        if (vld) begin
            if (!m_track) begin
                m_last  = cnt;
                m_track = 1;
            end else if (crst) begin
                m_w    = 0;
                m_last = cnt;
            end else begin
`ifdef WRAP_TRACK_STEP_CHK_EN
                if (cnt != (dir ? (m_last + 1) % 16 : (m_last + 15) % 16)) m_step = 1;
`endif
                if (dir && m_last == 15 && cnt == 0) begin
                    m_w++;
                    m_pend   = {1'b1, 8'(m_w)};
                    m_pend_v = 1;
                end else if (!dir && m_last == 0 && cnt == 15) begin
                    m_w--;
                    m_pend   = {1'b0, 8'(m_w)};
                    m_pend_v = 1;
                end
                m_last = cnt;
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, compare, advance model and DUT.
    task automatic cyc(input bit vld, input int cnt, input bit dir, input bit crst, input bit rdy);
        cnt_vld   = vld;
        count_in  = 4'(cnt);
        dir_in    = dir;
        cnt_rst   = crst;
        evt_ready = rdy;
        check_model("cyc");
        model_edge(vld, cnt, dir, crst, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic hard_reset();
        cnt_vld = 0; cnt_rst = 0; evt_ready = 0;
        rst_n = 1'b0;
        #2;
        chk("rst_pos",   pos,       12'h000);
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_data",  evt_data,  9'h000);
        chk("rst_drop",  drop_err,  1'b0);
        chk("rst_step",  step_err,  1'b0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit exp_step;
        model_clear();
        @(negedge clk);

        // 1: up wrap 14,15,0,1
        hard_reset();
        cyc(1, 14, 1, 0, 1);
        cyc(1, 15, 1, 0, 1);
        cyc(1, 0, 1, 0, 1);
        chk("t1_no_bypass", evt_valid, 1'b0);
        cyc(1, 1, 1, 0, 1);
        chk("t1_pos",   pos,       12'h011);
        chk("t1_valid", evt_valid, 1'b1);
        chk("t1_data",  evt_data,  9'h101);
        cyc(0, 1, 1, 0, 1);
        chk("t1_popped", evt_valid, 1'b0);

        // 2: down wrap 1,0,15,14
        hard_reset();
        cyc(1, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 15, 0, 0, 1);
        chk("t2_pos_m1", pos, 12'hFFF);
        cyc(1, 14, 0, 0, 1);
        chk("t2_pos",   pos,       12'hFFE);
        chk("t2_valid", evt_valid, 1'b1);
        chk("t2_data",  evt_data,  9'h0FF);

        // 3: five wraps with the consumer stalled -> one drop
        hard_reset();
        cyc(1, 15, 1, 0, 0);
        for (int k = 1; k <= 5; k++)
            for (int v = 0; v < 16; v++) cyc(1, v, 1, 0, 0);
        chk("t3_drop",  drop_err,  1'b1);
        chk("t3_valid", evt_valid, 1'b1);
        chk("t3_pos",   pos,       12'h05F);
        for (int i = 1; i <= 4; i++) begin
            chk("t3_drain", evt_data, 32'h100 + i);
            cyc(0, 15, 1, 0, 1);
        end
        chk("t3_empty", evt_valid, 1'b0);

        // 4: push into a full queue while popping -> no drop
        hard_reset();
        cyc(1, 15, 1, 0, 0);
        for (int k = 1; k <= 5; k++)
            for (int v = 0; v < 16; v++) cyc(1, v, 1, 0, (k == 5 && v == 1));
        chk("t4_drop", drop_err, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            chk("t4_valid", evt_valid, 1'b1);
            chk("t4_drain", evt_data, 32'h100 + i);
            cyc(0, 15, 1, 0, 1);
        end
        chk("t4_empty", evt_valid, 1'b0);

        // 5: counter reset mid-run, then async reset with state loaded
        hard_reset();
        cyc(1, 15, 1, 0, 0);
        for (int k = 1; k <= 3; k++)
            for (int v = 0; v < 16; v++) cyc(1, v, 1, 0, 0);
        chk("t5_pos_w3", pos, 12'h03F);
        cyc(1, 7, 1, 1, 0);
        chk("t5_pos",   pos,       12'h007);
        chk("t5_head",  evt_data,  9'h101);
        cyc(1, 8, 1, 0, 0);
        chk("t5_pos8",  pos,       12'h008);
        hard_reset();

        // 6: illegal step 3 -> 6
        cyc(1, 3, 1, 0, 1);
        cyc(1, 6, 1, 0, 1);
`ifdef WRAP_TRACK_STEP_CHK_EN
        exp_step = 1'b1;
`else
        exp_step = 1'b0;
`endif
        chk("t6_step", step_err, exp_step);
        chk("t6_pos",  pos,      12'h006);
        cyc(0, 6, 1, 0, 1);

        // Randomized walk against the model
        hard_reset();
        for (int n = 0; n < 600; n++) begin
            bit vld, dir, crst, rdy;
            int cnt;
            vld  = ($urandom_range(0, 9) != 0);
            dir  = $urandom_range(0, 1);
            crst = ($urandom_range(0, 24) == 0);
            rdy  = ((n / 40) % 2 == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) cnt = $urandom_range(0, 15);
            else cnt = dir ? (m_last + 1) % 16 : (m_last + 15) % 16;
            cyc(vld, cnt, dir, crst, rdy);
        end
        check_model("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
